// File: rtl/spi_rx_buffer_if.sv
// Bundle between the SPI receive buffer and its neighbours: the slave-side word
// strobe, the valid/ready output stream and the status outputs.
interface spi_rx_buffer_if #(
  parameter int DW    = 12,
  parameter int DEPTH = 8,
  parameter int CW    = 8
);
  logic                       rx_done;
  logic [DW-1:0]              rx_data;
  logic [DW-1:0]              out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     count;
  logic                       full;
  logic                       empty;
  logic                       overflow;
  logic [CW-1:0]              drop_cnt;
  logic                       clr_ovf;

  modport slave (
    input  rx_done, rx_data, out_ready, clr_ovf,
    output out_data, out_valid, count, full, empty, overflow, drop_cnt
  );

  modport master (
    output rx_done, rx_data, out_ready, clr_ovf,
    input  out_data, out_valid, count, full, empty, overflow, drop_cnt
  );
endinterface

// File: rtl/spi_rx_buffer.sv
// Synchronises the SPI slave word-complete flag into clk, captures each word once
// into a first-word-fall-through FIFO and reports occupancy and dropped words.
module spi_rx_buffer #(
  parameter int DW    = 12,
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_rx_buffer_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [1:0] {
    ST_COLD,
    ST_WAIT_LOW,
    ST_ARMED
  } arm_state_t;

  arm_state_t     state, state_next;
  logic           s1, s2, s3;
  logic           arm, push_req, pop, push_ok, drop;
  logic [DW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q, count_next;
  logic           full_q, empty_q, ovf_q;
  logic [CW-1:0]  drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      state <= ST_COLD;
    end else begin
      s1    <= bus.rx_done;
      s2    <= s1;
      s3    <= s2;
      state <= state_next;
    end
  end

  // The flops hold reset zeros for the first cycle, so arming waits until a
  // genuinely sampled low has reached s2; a flag held across reset never pushes.
  always_comb begin
    state_next = state;
    arm        = 1'b0;
    case (state)
      ST_COLD:     state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!s1 && !s2) state_next = ST_ARMED;
      ST_ARMED:    arm = 1'b1;
      default:     state_next = ST_COLD;
    endcase
  end

  assign push_req = arm & s2 & ~s3;
  assign pop      = ~empty_q & bus.out_ready;
  assign push_ok  = push_req & (~full_q | pop);
  assign drop     = push_req & full_q & ~pop;

  always_comb begin
    count_next = count_q;
    case ({push_ok, pop})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_next;
      full_q  <= (count_next == CNT_W'(DEPTH));
      empty_q <= (count_next == '0);
    end
  end

  // A drop in the same cycle as a clear restarts the tally at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (bus.clr_ovf)      drop_q <= CW'(1);
      else if (drop_q != '1) drop_q <= drop_q + CW'(1);
    end else if (bus.clr_ovf) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end
  end

  assign bus.out_valid = ~empty_q;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.overflow  = ovf_q;
  assign bus.drop_cnt  = drop_q;
endmodule
